// File: rtl/axi_burst_slave.sv
// AXI4 burst memory slave: FIXED/INCR/WRAP bursts up to 256 beats, byte strobes,
// narrow transfers and ID echo, with independent write and read state machines.
module axi_burst_slave #(
  parameter int addr_width = 12,
  parameter int data_width = 32,
  parameter int id_width   = 4,
  parameter int mem_depth  = 256
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [id_width-1:0]     awid,
  input  logic [addr_width-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [data_width-1:0]   wdata,
  input  logic [data_width/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [id_width-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [id_width-1:0]     arid,
  input  logic [addr_width-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [id_width-1:0]     rid,
  output logic [data_width-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB     = data_width / 8;
  localparam int STRB_LOG = $clog2(STRB);
  localparam int IDX_W    = addr_width - STRB_LOG;
  localparam int MEM_AW   = $clog2(mem_depth);

  typedef logic [addr_width-1:0] addr_t;

  // The INIT states hold the ready outputs low until the first edge after reset release.
  typedef enum logic [1:0] {W_INIT, W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_INIT, R_IDLE, R_DATA} rstate_t;

  function automatic addr_t nextAddr(input addr_t a, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
    addr_t bytes;
    addr_t aligned;
    addr_t incr;
    addr_t mask;
    bytes   = addr_t'(1) << size;
    aligned = a & ~(bytes - addr_t'(1));
    incr    = aligned + bytes;
    mask    = ((addr_t'(len) + addr_t'(1)) << size) - addr_t'(1);
    case (burst)
      2'b00:   nextAddr = a;
      2'b10:   nextAddr = (a & ~mask) | (incr & mask);
      default: nextAddr = incr;
    endcase
  endfunction

  function automatic logic burstErr(input logic [7:0] len, input logic [2:0] size,
                                    input logic [1:0] burst);
    logic err;
    err = (burst == 2'b11) || (size > 3'(STRB_LOG));
    if (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      err = 1'b1;
    return err;
  endfunction

  function automatic logic inRange(input addr_t a);
    logic [IDX_W:0] idx;
    idx = {1'b0, a[addr_width-1:STRB_LOG]};
    return idx < (IDX_W+1)'(mem_depth);
  endfunction

  function automatic logic [MEM_AW-1:0] memIdx(input addr_t a);
    return a[STRB_LOG +: MEM_AW];
  endfunction

  logic [data_width-1:0] mem_q [mem_depth];
  logic [mem_depth-1:0]  written_q;

  wstate_t             wstate_q, wstate_d;
  logic [id_width-1:0] wid_q, wid_d;
  addr_t               waddr_q, waddr_d;
  logic [7:0]          wlen_q, wlen_d;
  logic [2:0]          wsize_q, wsize_d;
  logic [1:0]          wburst_q, wburst_d;
  logic [7:0]          wcount_q, wcount_d;
  logic                werr_q, werr_d;
  logic                wberr_q, wberr_d;
  logic                memWe;

  rstate_t               rstate_q, rstate_d;
  logic [id_width-1:0]   rid_q, rid_d;
  addr_t                 raddr_q, raddr_d;
  logic [7:0]            rlen_q, rlen_d;
  logic [2:0]            rsize_q, rsize_d;
  logic [1:0]            rburst_q, rburst_d;
  logic [7:0]            rcount_q, rcount_d;
  logic                  rberr_q, rberr_d;
  logic [data_width-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;
  logic                  arFire;
  logic                  rStep;
  addr_t                 rdAddr;
  logic                  rdErr;
  logic                  rdOk;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) wstate_q <= W_INIT;
    else          wstate_q <= wstate_d;
  end

  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_INIT: wstate_d = W_IDLE;
      W_IDLE: if (awvalid) wstate_d = W_DATA;
      W_DATA: if (wvalid && wcount_q == wlen_q) wstate_d = W_RESP;
      W_RESP: if (bready) wstate_d = W_IDLE;
      default: wstate_d = W_INIT;
    endcase
  end

  always_comb begin
    awready = (wstate_q == W_IDLE);
    wready  = (wstate_q == W_DATA);
    bvalid  = (wstate_q == W_RESP);
    bid     = wid_q;
    bresp   = (wstate_q == W_RESP && werr_q) ? 2'b10 : 2'b00;
  end

  // A dropped beat (burst error or out of range) still advances the count so the burst completes.
  always_comb begin
    wid_d    = wid_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wsize_d  = wsize_q;
    wburst_d = wburst_q;
    wcount_d = wcount_q;
    werr_d   = werr_q;
    wberr_d  = wberr_q;
    memWe    = 1'b0;
    if (wstate_q == W_IDLE && awvalid) begin
      wid_d    = awid;
      waddr_d  = awaddr;
      wlen_d   = awlen;
      wsize_d  = awsize;
      wburst_d = awburst;
      wcount_d = 8'd0;
      wberr_d  = burstErr(awlen, awsize, awburst);
      werr_d   = burstErr(awlen, awsize, awburst);
    end else if (wstate_q == W_DATA && wvalid) begin
      if (!wberr_q && inRange(waddr_q)) memWe = 1'b1;
      else                              werr_d = 1'b1;
      if (wlast != (wcount_q == wlen_q)) werr_d = 1'b1;
      wcount_d = wcount_q + 8'd1;
      waddr_d  = nextAddr(waddr_q, wlen_q, wsize_q, wburst_q);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wid_q    <= '0;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wsize_q  <= '0;
      wburst_q <= '0;
      wcount_q <= '0;
      werr_q   <= 1'b0;
      wberr_q  <= 1'b0;
    end else begin
      wid_q    <= wid_d;
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wsize_q  <= wsize_d;
      wburst_q <= wburst_d;
      wcount_q <= wcount_d;
      werr_q   <= werr_d;
      wberr_q  <= wberr_d;
    end
  end

  // Storage itself is not reset; the written flags alone decide whether a word is valid.
  always_ff @(posedge aclk) begin
    if (memWe) begin
      for (int b = 0; b < STRB; b++) begin
        if (wstrb[b]) mem_q[memIdx(waddr_q)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)   written_q <= '0;
    else if (memWe) written_q[memIdx(waddr_q)] <= 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rstate_q <= R_INIT;
    else          rstate_q <= rstate_d;
  end

  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_INIT: rstate_d = R_IDLE;
      R_IDLE: if (arvalid) rstate_d = R_DATA;
      R_DATA: if (rready && rlast_q) rstate_d = R_IDLE;
      default: rstate_d = R_INIT;
    endcase
  end

  always_comb begin
    arready = (rstate_q == R_IDLE);
    rvalid  = (rstate_q == R_DATA);
    rid     = rid_q;
    rdata   = rdata_q;
    rresp   = rresp_q;
    rlast   = rlast_q;
  end

  // Each beat is fetched on the edge that accepts the previous one, so reads see pre-write data.
  always_comb begin
    rid_d    = rid_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rsize_d  = rsize_q;
    rburst_d = rburst_q;
    rcount_d = rcount_q;
    rberr_d  = rberr_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    arFire   = (rstate_q == R_IDLE) && arvalid;
    rStep    = (rstate_q == R_DATA) && rready && !rlast_q;
    rdAddr   = arFire ? araddr : nextAddr(raddr_q, rlen_q, rsize_q, rburst_q);
    rdErr    = arFire ? burstErr(arlen, arsize, arburst) : rberr_q;
    rdOk     = !rdErr && inRange(rdAddr) && written_q[memIdx(rdAddr)];
    if (arFire) begin
      rid_d    = arid;
      rlen_d   = arlen;
      rsize_d  = arsize;
      rburst_d = arburst;
      rberr_d  = rdErr;
      rcount_d = 8'd0;
      rlast_d  = (arlen == 8'd0);
    end else if (rStep) begin
      rcount_d = rcount_q + 8'd1;
      rlast_d  = (rcount_q + 8'd1 == rlen_q);
    end
    if (arFire || rStep) begin
      raddr_d = rdAddr;
      rdata_d = rdOk ? mem_q[memIdx(rdAddr)] : '0;
      rresp_d = rdOk ? 2'b00 : 2'b10;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rid_q    <= '0;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rsize_q  <= '0;
      rburst_q <= '0;
      rcount_q <= '0;
      rberr_q  <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rlast_q  <= 1'b0;
    end else begin
      rid_q    <= rid_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rsize_q  <= rsize_d;
      rburst_q <= rburst_d;
      rcount_q <= rcount_d;
      rberr_q  <= rberr_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
    end
  end

endmodule

// File: doc/axi_burst_slave.md
Name: axi_burst_slave

Overview:
Parametrised AXI4 memory slave with full burst support: FIXED/INCR/WRAP bursts of up to 256 beats, byte strobes, narrow transfers, and ID echo. Write and read channels run independent state machines over a one-write/one-read-port word memory with per-word "written" flags. Replaces the single-beat 8-word test slave as the bus-attached memory model and target for the AXI master and interconnect blocks.

Parameters:
addr_width, 12, byte address width
data_width, 32, data bus width (32 or 64); strobe width strb = data_width/8
id_width, 4, AXI ID width
mem_depth, 256, number of data_width words; 2^addr_width >= mem_depth*strb

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
awid  in  id_width  write ID
awaddr  in  addr_width  write start byte address
awlen  in  8  beats-1
awsize  in  3  log2 bytes per beat
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
awvalid / awready  in / out  1  AW handshake
wdata  in  data_width  write data
wstrb  in  strb  byte enables
wlast  in  1  last write beat
wvalid / wready  in / out  1  W handshake
bid  out  id_width  = latched awid
bresp  out  2  00 OKAY, 10 SLVERR
bvalid / bready  out / in  1  B handshake
arid, araddr, arlen, arsize, arburst  in  id_width, addr_width, 8, 3, 2  read address fields
arvalid / arready  in / out  1  AR handshake
rid  out  id_width  = latched arid
rdata  out  data_width  read data
rresp  out  2  per-beat response
rlast  out  1  last read beat
rvalid / rready  out / in  1  R handshake

Behaviour:
- Reset (async, aresetn=0): all outputs 0, both FSMs idle, all written-flags cleared; memory contents undefined. awready/arready rise at first aclk rising edge after aresetn=1. Reset mid-burst aborts it; no response issued.
- Word index = byte address >> log2(strb). Beat address: FIXED constant; INCR next = (addr aligned down to 2^size) + 2^size; WRAP as INCR but wraps within aligned block of (len+1)*2^size bytes.
- Burst error (whole burst SLVERR, memory untouched, all beats still consumed/returned): burst==11; WRAP with len not in {1,3,7,15}; size > log2(strb).
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1, wready=0. AW handshake latches id/addr/len/size/burst, beat count=0, err=0; next W_DATA (awready=0, wready=1). W beats before AW are not accepted.
  - W_DATA: each W handshake writes bytes with wstrb=1 into word, sets its written-flag, increments count/address. Word index >= mem_depth: beat dropped, err=1. wlast must equal (count==len); mismatch sets err. Beat with count==len ends data phase -> W_RESP (wready=0, bvalid=1, bid, bresp = err?10:00).
  - W_RESP: hold bvalid/bid/bresp until bready; after handshake -> W_IDLE, bvalid=0, awready=1 next cycle.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: arready=1. AR handshake at edge N latches fields; at that same edge rdata/rresp for beat 0 registered from araddr, rvalid=1, rlast=(arlen==0), arready=0.
  - R_DATA: rvalid, rdata, rresp, rlast, rid held stable while rready=0. On R handshake: if rlast, rvalid=0 and -> R_IDLE; else next beat registered same edge (back-to-back, one beat/cycle with rready=1).
  - Per-beat rresp: burst error or out-of-range -> rdata=0, 10; word never written -> rdata=0, 10; else memory word, 00.
- Simultaneous write and read of same word in same cycle: read returns pre-write value. Read/write channels never stall each other.
- Narrow transfers: rdata returns the whole word; master selects lanes.

Test Plan:
- Reset, AW addr 0x010 INCR len 3 size 2, wdata 0x11111111..0x44444444 wstrb 0xF -> bresp 00, bid=awid; AR same -> 4 beats in order, rlast on beat 4, rresp 00.
- WRAP len 3 size 2 at 0x018 -> words written 0x018,0x01C,0x010,0x014; INCR readback of 0x010 len 3 returns data in that rotated order.
- Partial strobe: write 0xAABBCCDD to 0x020 wstrb 0xF, then 0x11223344 wstrb 0x5 -> read 0x020 gives 0xAA22CC44.
- Read unwritten 0x080 and FIXED burst len 2 -> rdata 0, rresp 10 every beat; burst=11 write -> bresp 10, memory unchanged.
- rready toggled randomly over 8-beat read -> no beat lost/duplicated, rdata stable while stalled; wlast early on beat 2 of len 3 -> bresp 10.
- aresetn pulsed low mid 16-beat write -> outputs 0 immediately, flags cleared; new burst after reset completes OKAY.
